// File: rtl/dashed_net_renderer.sv
// Multi-channel vertical dashed-line renderer with frame-latched settings, line-driven phase
// tracking, optional per-frame scrolling and a fixed two-stage hit pipeline.
module dashed_net_renderer #(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned X_W      = 10,
    parameter int unsigned Y_W      = 9
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    frame_start,
    input  logic                    line_start,
    input  logic [X_W-1:0]          PollX,
    input  logic [Y_W-1:0]          PollY,
    input  logic [CHANNELS*X_W-1:0] LineX,
    input  logic [3:0]              LineW,
    input  logic [4:0]              DashLen,
    input  logic [4:0]              GapLen,
    input  logic                    ScrollEn,
    input  logic                    ScrollDir,
    input  logic [3:0]              ScrollStep,
    output logic [CHANNELS-1:0]     Hit,
    output logic [CHANNELS-1:0]     Hit2,
    output logic                    AnyHit
);

    logic [CHANNELS*X_W-1:0] x_q;
    logic [3:0]              w_q;
    logic [4:0]              dash_q, gap_q;
    logic [5:0]              offset_q, phase_q;
    logic                    armed_q;
    logic [CHANNELS-1:0]     in_x_q;
    logic                    dash_s1_q;

    logic [4:0]              dash_n, gap_n, dash_c;
    logic [5:0]              period_n, period_q, step, offset_n, phase_c;
    logic [6:0]              down_t, up_t, up_wrap;
    logic [CHANNELS*X_W-1:0] x_c;
    logic [3:0]              w_c;
    logic                    armed_c, dash_c_hit;
    logic [CHANNELS-1:0]     in_x_c;

    assign dash_n   = (DashLen == 5'd0) ? 5'd1 : DashLen;
    assign gap_n    = (GapLen == 5'd0) ? 5'd1 : GapLen;
    assign period_n = {1'b0, dash_n} + {1'b0, gap_n};
    assign period_q = {1'b0, dash_q} + {1'b0, gap_q};
    assign step     = ({2'b00, ScrollStep} >= period_n) ? period_n - 6'd1 : {2'b00, ScrollStep};
    assign down_t   = {1'b0, offset_q} - {1'b0, step};
    assign up_t     = {1'b0, offset_q} + {1'b0, step};
    assign up_wrap  = up_t - {1'b0, period_n};

    always_comb begin
        offset_n = offset_q;
        if (ScrollEn) begin
            if (!ScrollDir) begin
                // Borrow means the subtraction went negative; fold back by one period.
                offset_n = down_t[6] ? down_t[5:0] + period_n : down_t[5:0];
            end else begin
                offset_n = (up_t >= {1'b0, period_n}) ? up_wrap[5:0] : up_t[5:0];
            end
        end else if (offset_q >= period_n) begin
            offset_n = offset_q - period_n;
        end
    end

    // Values in effect for the pixel presented this cycle.
    always_comb begin
        x_c     = frame_start ? LineX : x_q;
        w_c     = frame_start ? LineW : w_q;
        dash_c  = frame_start ? dash_n : dash_q;
        armed_c = armed_q | frame_start;
        phase_c = phase_q;
        if (frame_start) begin
            phase_c = offset_n;
        end else if (line_start) begin
            phase_c = (phase_q >= period_q - 6'd1) ? 6'd0 : phase_q + 6'd1;
        end
        dash_c_hit = phase_c < {1'b0, dash_c};
    end

    always_comb begin
        logic [X_W-1:0] lo;
        logic [X_W:0]   hi;
        in_x_c = '0;
        lo     = '0;
        hi     = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            lo        = x_c[i*X_W +: X_W];
            hi        = {1'b0, lo} + (X_W+1)'(w_c);
            in_x_c[i] = armed_c && (PollX >= lo) && ({1'b0, PollX} <= hi);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q       <= '0;
            w_q       <= '0;
            dash_q    <= 5'd1;
            gap_q     <= 5'd1;
            offset_q  <= '0;
            phase_q   <= '0;
            armed_q   <= 1'b0;
            in_x_q    <= '0;
            dash_s1_q <= 1'b0;
            Hit       <= '0;
            Hit2      <= '0;
            AnyHit    <= 1'b0;
        end else begin
            if (frame_start) begin
                x_q      <= LineX;
                w_q      <= LineW;
                dash_q   <= dash_n;
                gap_q    <= gap_n;
                offset_q <= offset_n;
                armed_q  <= 1'b1;
            end
            phase_q   <= phase_c;
            in_x_q    <= in_x_c;
            dash_s1_q <= dash_c_hit;
            Hit       <= in_x_q & {CHANNELS{dash_s1_q}};
            Hit2      <= in_x_q & ~{CHANNELS{dash_s1_q}};
            AnyHit    <= |in_x_q;
        end
    end

endmodule

// File: tb/tb_dashed_net_renderer.sv
// Directed bench for dashed_net_renderer: table-driven first frame, then hand-written
// sequences for scrolling, frame-latched settings and mid-frame reset.
module tb_dashed_net_renderer;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_start, line_start;
    logic [9:0]  PollX;
    logic [8:0]  PollY;
    logic [19:0] LineX;
    logic [3:0]  LineW;
    logic [4:0]  DashLen, GapLen;
    logic        ScrollEn, ScrollDir;
    logic [3:0]  ScrollStep;
    logic [1:0]  Hit, Hit2;
    logic        AnyHit;

    dashed_net_renderer #(.CHANNELS(2), .X_W(10), .Y_W(9)) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .line_start(line_start),
        .PollX(PollX), .PollY(PollY), .LineX(LineX), .LineW(LineW),
        .DashLen(DashLen), .GapLen(GapLen), .ScrollEn(ScrollEn), .ScrollDir(ScrollDir),
        .ScrollStep(ScrollStep), .Hit(Hit), .Hit2(Hit2), .AnyHit(AnyHit)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       fs;
        logic       ls;
        logic [9:0] x;
        logic [1:0] h;
        logic [1:0] h2;
    } vec_t;

    vec_t       tab[$];
    int         n_cmp = 0;
    int         n_fail = 0;
    string      tag = "init";
    logic       pend_v = 1'b0;
    logic [1:0] pend_h, pend_h2;

    task automatic check(input string name, input logic [4:0] got, input logic [4:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: {Hit,Hit2,AnyHit} got %b want %b", name, got, want);
        end
    endtask

    // Outputs seen after the edge that captures pixel m belong to pixel m-1.
    task automatic pix(input logic fs, input logic ls, input logic [9:0] x,
                       input logic [1:0] h, input logic [1:0] h2);
        frame_start = fs;
        line_start  = ls;
        PollX       = x;
        PollY       = PollY + 9'(ls);
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        line_start  = 1'b0;
        if (pend_v) check(tag, {Hit, Hit2, AnyHit}, {pend_h, pend_h2, |{pend_h, pend_h2}});
        pend_h  = h;
        pend_h2 = h2;
        pend_v  = 1'b1;
    endtask

    task automatic line(input logic fs, input logic d);
        pix(fs, 1'b1, 10'd320, d ? 2'b01 : 2'b00, d ? 2'b00 : 2'b01);
        pix(1'b0, 1'b0, 10'd103, d ? 2'b10 : 2'b00, d ? 2'b00 : 2'b10);
        pix(1'b0, 1'b0, 10'd324, 2'b00, 2'b00);
    endtask

    function automatic logic exp_dash(int l, int off, int d, int g);
        return ((off + l) % (d + g)) < d;
    endfunction

    initial begin
        logic [11:0] pat;
        logic        d;
        reset = 1'b0;
        frame_start = 1'b0;
        line_start = 1'b0;
        PollX = '0;
        PollY = '0;
        LineX = {10'd100, 10'd320};
        LineW = 4'd3;
        DashLen = 5'd4;
        GapLen = 5'd4;
        ScrollEn = 1'b0;
        ScrollDir = 1'b0;
        ScrollStep = 4'd3;

        // Lines 0-3 dash, 4-7 gap, 8-11 dash.
        pat = 12'b1111_0000_1111;
        for (int l = 0; l < 12; l++) begin
            d = pat[l];
            tab.push_back('{fs: (l == 0), ls: 1'b1, x: 10'd320,
                            h: d ? 2'b01 : 2'b00, h2: d ? 2'b00 : 2'b01});
            tab.push_back('{fs: 1'b0, ls: 1'b0, x: 10'd323,
                            h: d ? 2'b01 : 2'b00, h2: d ? 2'b00 : 2'b01});
            tab.push_back('{fs: 1'b0, ls: 1'b0, x: 10'd324, h: 2'b00, h2: 2'b00});
            tab.push_back('{fs: 1'b0, ls: 1'b0, x: 10'd100,
                            h: d ? 2'b10 : 2'b00, h2: d ? 2'b00 : 2'b10});
            tab.push_back('{fs: 1'b0, ls: 1'b0, x: 10'd99, h: 2'b00, h2: 2'b00});
        end

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {Hit, Hit2, AnyHit}, 5'b0);
        reset = 1'b1;

        // Not armed: x=0 matches the reset shadows but nothing may be reported.
        tag = "pre_arm";
        for (int l = 0; l < 5; l++) begin
            pix(1'b0, 1'b1, 10'd0, 2'b00, 2'b00);
            pix(1'b0, 1'b0, 10'd320, 2'b00, 2'b00);
        end

        tag = "table_4_4";
        foreach (tab[k]) pix(tab[k].fs, tab[k].ls, tab[k].x, tab[k].h, tab[k].h2);

        tag = "zero_len";
        DashLen = 5'd0;
        GapLen = 5'd0;
        for (int l = 0; l < 6; l++) line(l == 0, exp_dash(l, 0, 1, 1));

        tag = "scroll_off0";
        DashLen = 5'd4;
        GapLen = 5'd4;
        for (int l = 0; l < 3; l++) line(l == 0, exp_dash(l, 0, 4, 4));
        ScrollEn = 1'b1;
        tag = "scroll_off5";
        for (int l = 0; l < 5; l++) line(l == 0, exp_dash(l, 5, 4, 4));
        tag = "scroll_off2";
        for (int l = 0; l < 5; l++) line(l == 0, exp_dash(l, 2, 4, 4));
        tag = "scroll_off7";
        for (int l = 0; l < 5; l++) line(l == 0, exp_dash(l, 7, 4, 4));

        // Offset stays 7; DashLen change at line 100 must wait for the next frame.
        ScrollEn = 1'b0;
        tag = "midframe_old";
        for (int l = 0; l < 104; l++) begin
            if (l == 100) DashLen = 5'd6;
            line(l == 0, exp_dash(l, 7, 4, 4));
        end
        tag = "midframe_new";
        for (int l = 0; l < 201; l++) line(l == 0, exp_dash(l, 7, 6, 4));

        // Line 200 is a gap line, so Hit2/AnyHit are high right before reset.
        tag = "reset_async";
        reset = 1'b0;
        #1;
        check("reset_async", {Hit, Hit2, AnyHit}, 5'b0);
        pend_v = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;

        tag = "post_reset_unarmed";
        for (int l = 0; l < 4; l++) begin
            pix(1'b0, 1'b1, 10'd0, 2'b00, 2'b00);
            pix(1'b0, 1'b0, 10'd0, 2'b00, 2'b00);
        end
        tag = "post_reset_frame";
        for (int l = 0; l < 8; l++) line(l == 0, exp_dash(l, 0, 6, 4));
        tag = "flush";
        pix(1'b0, 1'b0, 10'd0, 2'b00, 2'b00);
        pix(1'b0, 1'b0, 10'd0, 2'b00, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
